// File: rtl/shl_6piso_if.sv
// Parallel-word handshake and serial-line bundle for the 6-bit PISO.
interface shl_6piso_if;
    logic       EN;
    logic       LOAD;
    logic [5:0] DIN;
    logic       ACCEPT;
    logic       DOUT;
    logic       FRAME;
    logic       BUSY;
    logic       DONE;

    modport master (
        output EN, LOAD, DIN,
        input  ACCEPT, DOUT, FRAME, BUSY, DONE
    );

    modport slave (
        input  EN, LOAD, DIN,
        output ACCEPT, DOUT, FRAME, BUSY, DONE
    );
endinterface

// File: rtl/shl_6piso.sv
// 6-bit parallel-in serial-out shifter, MSB first, with a one-word holding
// register so that consecutive words go out back to back with no gap bit.
//
// state | meaning
// IDLE  | no word on DOUT; DOUT=0, BUSY=0; waits for an EN edge with HOLD full
// SHIFT | a word is on DOUT; CNT is the index of the bit currently shown
module shl_6piso (
    input  logic         CLK,
    input  logic         RST,
    shl_6piso_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] hold, hold_nxt;
    logic       hfull, hfull_nxt;
    logic [5:0] sreg, sreg_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       dout, dout_nxt;
    logic       frame, frame_nxt;
    logic       busy, busy_nxt;
    logic       done, done_nxt;

    // State and datapath registers, cleared asynchronously by RST.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            hold  <= 6'd0;
            hfull <= 1'b0;
            sreg  <= 6'd0;
            cnt   <= 3'd0;
            dout  <= 1'b0;
            frame <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            hfull <= hfull_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            frame <= frame_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic: parallel load into HOLD, and the serial sequencer that
    // advances only on EN. A load needs HFULL=0 and a word start needs HFULL=1,
    // so both can never fire on the same edge.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        hfull_nxt = hfull;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        frame_nxt = frame;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        if (bus.LOAD && !hfull) begin
            hold_nxt  = bus.DIN;
            hfull_nxt = 1'b1;
        end

        if (bus.EN) begin
            case (state)
                IDLE: begin
                    if (hfull) begin
                        sreg_nxt  = hold;
                        dout_nxt  = hold[5];
                        frame_nxt = 1'b1;
                        cnt_nxt   = 3'd5;
                        hfull_nxt = 1'b0;
                        busy_nxt  = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 3'd0) begin
                        sreg_nxt  = {sreg[4:0], 1'b0};
                        dout_nxt  = sreg[4];
                        cnt_nxt   = cnt - 3'd1;
                        frame_nxt = 1'b0;
                    end else begin
                        done_nxt = 1'b1;
                        if (hfull) begin
                            sreg_nxt  = hold;
                            dout_nxt  = hold[5];
                            frame_nxt = 1'b1;
                            cnt_nxt   = 3'd5;
                            hfull_nxt = 1'b0;
                            busy_nxt  = 1'b1;
                            state_nxt = SHIFT;
                        end else begin
                            dout_nxt  = 1'b0;
                            frame_nxt = 1'b0;
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.ACCEPT = !hfull;
    assign bus.DOUT   = dout;
    assign bus.FRAME  = frame;
    assign bus.BUSY   = busy;
    assign bus.DONE   = done;

endmodule
